// File: rtl/key_schedule_pkg.sv
// Shared AES-128 key-schedule types, constants and byte-level helpers.
package key_schedule_pkg;

   localparam int NUM_ROUNDS = 10;
   localparam int KEY_W      = 128;
   localparam logic [7:0] RCON_INIT = 8'h01;

   typedef logic [NUM_ROUNDS:0][KEY_W-1:0] roundkeys_t;

   typedef enum logic {
      IDLE,
      EXPAND
   } ks_state_e;

   // Forward S-box, entry 0 is the leftmost byte.
   localparam logic [0:255][7:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX_TABLE[x];
   endfunction

endpackage

// File: rtl/key_schedule_step.sv
// Combinational single AES-128 key expansion step: next round key from the previous one.
module key_expansion_step
   import key_schedule_pkg::*;
(
   input  logic [KEY_W-1:0] Key_DI,
   input  logic [7:0]       Rcon_DI,
   output logic [KEY_W-1:0] NextKey_DO
);

   logic [31:0] w0, w1, w2, w3;
   logic [31:0] rot_word, sub_word, t_word;
   logic [31:0] n0, n1, n2, n3;

   assign {w0, w1, w2, w3} = Key_DI;

   // Byte 0 (most significant) rotates to the least significant position.
   assign rot_word = {w3[23:0], w3[31:24]};

   for (genvar b = 0; b < 4; b++) begin : g_sbox
      assign sub_word[8*b +: 8] = sbox(rot_word[8*b +: 8]);
   end

   assign t_word = sub_word ^ {Rcon_DI, 24'h000000};

   assign n0 = w0 ^ t_word;
   assign n1 = w1 ^ n0;
   assign n2 = w2 ^ n1;
   assign n3 = w3 ^ n2;

   assign NextKey_DO = {n0, n1, n2, n3};

endmodule

// File: rtl/key_schedule.sv
// Iterative AES-128 key expansion: one round key per cycle, all eleven held in registers.
module key_schedule
   import key_schedule_pkg::*;
(
   input  logic             Clk_CI,
   input  logic             Reset_RBI,
   input  logic [KEY_W-1:0] Key_DI,
   input  logic             Start_SI,
   output logic             Busy_SO,
   output logic             Valid_SO,
   output roundkeys_t       Roundkeys_DO
);

   localparam logic [3:0] LAST_CNT = 4'(NUM_ROUNDS);

   ks_state_e        state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [7:0]       rcon_q, rcon_d;
   roundkeys_t       rk_q, rk_d;
   logic             valid_q, valid_d;
   logic [KEY_W-1:0] prev_key, next_key;

   assign prev_key = rk_q[cnt_q - 4'd1];

   key_expansion_step u_step (
      .Key_DI     (prev_key),
      .Rcon_DI    (rcon_q),
      .NextKey_DO (next_key)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rcon_d  = rcon_q;
      rk_d    = rk_q;
      valid_d = valid_q;
      case (state_q)
         IDLE: begin
            if (Start_SI) begin
               rk_d[0] = Key_DI;
               cnt_d   = 4'd1;
               rcon_d  = RCON_INIT;
               valid_d = 1'b0;
               state_d = EXPAND;
            end
         end
         EXPAND: begin
            // Start_SI is deliberately ignored here; no request is queued.
            rk_d[cnt_q] = next_key;
            rcon_d      = xtime(rcon_q);
            cnt_d       = cnt_q + 4'd1;
            if (cnt_q == LAST_CNT) begin
               state_d = IDLE;
               valid_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk_CI) begin
      if (!Reset_RBI) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rcon_q  <= RCON_INIT;
         rk_q    <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rcon_q  <= rcon_d;
         rk_q    <= rk_d;
         valid_q <= valid_d;
      end
   end

   assign Busy_SO      = (state_q == EXPAND);
   assign Valid_SO     = valid_q;
   assign Roundkeys_DO = rk_q;

endmodule

// File: tb/tb_key_schedule.sv
// Randomized bench for key_schedule against a word-level FIPS-197 key expansion model.
module tb_key_schedule;
   import key_schedule_pkg::*;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [127:0] key;
   logic         start;
   logic         busy, valid;
   roundkeys_t   rk_o;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0]   sb_m [256];
   logic [127:0] exp_rk [11];

   key_schedule dut (
      .Clk_CI       (clk),
      .Reset_RBI    (rst_n),
      .Key_DI       (key),
      .Start_SI     (start),
      .Busy_SO      (busy),
      .Valid_SO     (valid),
      .Roundkeys_DO (rk_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      return (v << n) | (v >> (8 - n));
   endfunction

   // S-box from its definition: multiplicative inverse followed by the affine map.
   task automatic build_sbox();
      for (int a = 0; a < 256; a++) begin
         logic [7:0] inv = 8'h00;
         for (int b = 1; b < 256; b++)
            if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
         sb_m[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sb_m[w[31:24]], sb_m[w[23:16]], sb_m[w[15:8]], sb_m[w[7:0]]};
   endfunction

   task automatic model_expand(input logic [127:0] k);
      logic [31:0] w [44];
      logic [31:0] tmp;
      logic [7:0]  rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
            rc  = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   // AES-128 encryption using the DUT's round keys.
   task automatic aes_encrypt(input logic [127:0] pt, output logic [127:0] ct);
      logic [7:0] s [16];
      logic [7:0] t [16];
      logic [127:0] st = pt ^ rk_o[0];
      for (int r = 1; r <= 10; r++) begin
         for (int i = 0; i < 16; i++) s[i] = sb_m[st[127 - 8*i -: 8]];
         for (int c = 0; c < 4; c++)
            for (int rw = 0; rw < 4; rw++) t[rw + 4*c] = s[rw + 4*((c + rw) % 4)];
         if (r < 10) begin
            for (int c = 0; c < 4; c++) begin
               s[4*c]   = gmul(t[4*c], 2) ^ gmul(t[4*c+1], 3) ^ t[4*c+2] ^ t[4*c+3];
               s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 2) ^ gmul(t[4*c+2], 3) ^ t[4*c+3];
               s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 2) ^ gmul(t[4*c+3], 3);
               s[4*c+3] = gmul(t[4*c], 3) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 2);
            end
         end else begin
            for (int i = 0; i < 16; i++) s[i] = t[i];
         end
         for (int i = 0; i < 16; i++) st[127 - 8*i -: 8] = s[i];
         st = st ^ rk_o[r];
      end
      ct = st;
   endtask

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic chk_all_rk(input string tag);
      for (int r = 0; r < 11; r++) chk($sformatf("%s_rk%0d", tag, r), rk_o[r], exp_rk[r]);
   endtask

   // One expansion; Key_DI is scrambled right after the start sample.
   task automatic run_key(input string tag, input logic [127:0] k);
      int edges;
      model_expand(k);
      key   = k;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      key   = rand128();
      edges = 1;
      chk({tag, "_busy1"}, 128'(busy), 128'(1'b1));
      chk({tag, "_rk0_early"}, rk_o[0], k);
      while (!valid && edges < 20) begin
         @(posedge clk); #1;
         edges++;
         key = rand128();
      end
      chk({tag, "_latency"}, 128'(edges), 128'(11));
      chk({tag, "_busy_done"}, 128'(busy), 128'(1'b0));
      chk_all_rk(tag);
   endtask

   initial begin
      logic [127:0] ct;
      logic [127:0] key_at [3];
      logic [127:0] k;

      build_sbox();
      rst_n = 1'b0;
      start = 1'b0;
      key   = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", 128'(valid), 128'(1'b0));
      chk("rst_busy", 128'(busy), 128'(1'b0));
      for (int r = 0; r < 11; r++) chk($sformatf("rst_rk%0d", r), rk_o[r], 128'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // FIPS-197 A.1 key plus end-to-end encryption.
      run_key("fips", 128'h2b7e151628aed2a6abf7158809cf4f3c);
      chk("fips_rk1_const", rk_o[1], 128'ha0fafe1788542cb123a339392a6c7605);
      chk("fips_rk10_const", rk_o[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      aes_encrypt(128'h3243f6a8885a308d313198a2e0370734, ct);
      chk("fips_cipher", ct, 128'h3925841d02dc09fbdc118597196a0b32);

      // All-zero key.
      run_key("zero", 128'h0);
      chk("zero_rk1_const", rk_o[1], 128'h62636363626363636263636362636363);
      chk("zero_rk10_const", rk_o[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

      for (int i = 0; i < 4; i++) run_key($sformatf("rnd%0d", i), rand128());

      // Start held high with Key_DI changing every cycle.
      key   = rand128();
      start = 1'b1;
      for (int j = 1; j <= 33; j++) begin
         @(posedge clk);
         if ((j - 1) % 11 == 0) key_at[(j - 1) / 11] = key;
         #1;
         chk($sformatf("hold_valid_e%0d", j), 128'(valid), 128'(j % 11 == 0));
         chk($sformatf("hold_busy_e%0d", j), 128'(busy), 128'(j % 11 != 0));
         if (j % 11 == 0) begin
            model_expand(key_at[j / 11 - 1]);
            chk_all_rk($sformatf("hold_run%0d", j / 11));
         end
         key = rand128();
      end
      start = 1'b0;
      @(posedge clk); #1;

      // Reset in the middle of an expansion.
      key   = rand128();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("mid_busy_before_rst", 128'(busy), 128'(1'b1));
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("midrst_valid", 128'(valid), 128'(1'b0));
      chk("midrst_busy", 128'(busy), 128'(1'b0));
      for (int r = 0; r < 11; r++) chk($sformatf("midrst_rk%0d", r), rk_o[r], 128'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      k = rand128();
      run_key("after_rst", k);

      // Restart from valid: Valid_SO must drop on the next edge.
      key   = rand128();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("restart_valid_drop", 128'(valid), 128'(1'b0));
      repeat (12) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
